// File: rtl/alive_pkg.sv
// Shared types and constants for the note sequencer: FSM states, ROM entry
// layout, end-of-song marker and the pitch-to-half-period lookup (10 MHz clock).
package alive_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    PLAY,
    GAP,
    DONE
  } seq_state_t;

  typedef struct packed {
    logic [4:0] pitch;
    logic [2:0] dur;
  } note_t;

  localparam logic [7:0] END_MARKER = 8'h07;

  // Chromatic scale C4..F#6; entry 0 is a rest.
  localparam logic [15:0] PITCH_TABLE [32] = '{
    16'd0,
    16'd19111, 16'd18039, 16'd17026, 16'd16071, 16'd15169, 16'd14317,
    16'd13514, 16'd12755, 16'd12039, 16'd11364, 16'd10726, 16'd10124,
    16'd9556,  16'd9019,  16'd8513,  16'd8035,  16'd7584,  16'd7159,
    16'd6757,  16'd6378,  16'd6020,  16'd5682,  16'd5363,  16'd5062,
    16'd4778,  16'd4510,  16'd4257,  16'd4018,  16'd3792,  16'd3579,
    16'd3378
  };

  // Last millisecond index of a note: (dur+1)*base_ms - 1.
  function automatic logic [15:0] play_last_ms(input logic [2:0] dur,
                                               input logic [15:0] base_ms);
    return ({13'd0, dur} + 16'd1) * base_ms - 16'd1;
  endfunction

endpackage

// File: rtl/note_sequencer_ms_tick.sv
// Millisecond strobe generator: counts clk cycles up to ticks_per_milli
// (0 behaves as 1) and pulses tick for one cycle at each wrap.
module ms_tick (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        restart,
  input  logic [15:0] ticks_per_milli,
  output logic        tick
);

  logic [15:0] count_reg;
  logic [15:0] limit_reg;
  logic [15:0] limit_next;

  assign limit_next = (ticks_per_milli == 16'd0) ? 16'd1 : ticks_per_milli;
  assign tick       = (count_reg == limit_reg - 16'd1);

  // The period is latched only on restart or wrap, so a mid-note change of
  // ticks_per_milli never truncates the millisecond in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
      limit_reg <= 16'd1;
    end else if (restart || tick) begin
      count_reg <= '0;
      limit_reg <= limit_next;
    end else begin
      count_reg <= count_reg + 16'd1;
    end
  end

endmodule

// File: rtl/note_sequencer.sv
// Song sequencer: walks the note ROM and drives a stable tone/LED interface.
// Define SEQ_LOOP_EN to replay the song while start stays high.
module note_sequencer
  import alive_pkg::*;
#(
  parameter int SONG_LEN = 32,
  parameter int BASE_MS  = 125,
  parameter int GAP_MS   = 10,
  localparam int IDX_W   = (SONG_LEN > 1) ? $clog2(SONG_LEN) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [15:0]      ticks_per_milli,
  output logic [IDX_W-1:0] rom_addr,
  input  logic [7:0]       rom_data,
  output logic [15:0]      tone_half_period,
  output logic             tone_en,
  output logic [7:0]       led,
  output logic             busy,
  output logic             done
);

  localparam logic [15:0] GAP_LAST = (GAP_MS > 0) ? 16'(GAP_MS - 1) : 16'd0;

  seq_state_t       state_reg, state_next;
  logic [IDX_W-1:0] index_reg, index_next;
  note_t            note_reg, note_next;
  logic [15:0]      half_reg, half_next;
  logic [15:0]      ms_cnt_reg, ms_cnt_next;
  logic             tone_en_reg, tone_en_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
  logic [7:0]       led_reg, led_next;
  logic             ms_tick_w;
  logic             restart;
  logic             advance;
  logic             last_index;
  logic [15:0]      play_last;

  ms_tick u_ms_tick (
    .clk             (clk),
    .rst_n           (rst_n),
    .restart         (restart),
    .ticks_per_milli (ticks_per_milli),
    .tick            (ms_tick_w)
  );

  assign play_last  = play_last_ms(note_reg.dur, 16'(BASE_MS));
  assign last_index = ((int'(index_reg) + 1) == SONG_LEN);
  // Any state change re-arms both timers so each PLAY/GAP starts a full ms.
  assign restart    = (state_next != state_reg);

  always_comb begin
    state_next = state_reg;
    index_next = index_reg;
    note_next  = note_reg;
    half_next  = half_reg;
    advance    = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) state_next = FETCH;
      end
      FETCH: begin
        if (rom_data == END_MARKER) begin
          state_next = DONE;
        end else begin
          state_next = PLAY;
          note_next  = note_t'(rom_data);
          half_next  = PITCH_TABLE[rom_data[7:3]];
        end
      end
      PLAY: begin
        if (ms_tick_w && (ms_cnt_reg == play_last)) begin
          if (GAP_MS == 0) advance = 1'b1;
          else             state_next = GAP;
        end
      end
      GAP: begin
        if (ms_tick_w && (ms_cnt_reg == GAP_LAST)) advance = 1'b1;
      end
      DONE: begin
`ifdef SEQ_LOOP_EN
        if (start) begin
          state_next = FETCH;
          index_next = '0;
        end else begin
          state_next = IDLE;
        end
`else
        state_next = IDLE;
`endif
      end
      default: state_next = IDLE;
    endcase

    if (advance) begin
      if (last_index) begin
        state_next = DONE;
      end else begin
        state_next = FETCH;
        index_next = index_reg + IDX_W'(1);
      end
    end

    if (stop) state_next = IDLE;

    if (state_next == IDLE) begin
      index_next = '0;
      note_next  = '0;
      half_next  = '0;
    end

    ms_cnt_next  = restart ? 16'd0 : (ms_tick_w ? ms_cnt_reg + 16'd1 : ms_cnt_reg);
    busy_next    = (state_next != IDLE);
    done_next    = (state_next == DONE);
    tone_en_next = (state_next == PLAY) && (note_next.pitch != 5'd0);
    led_next     = {busy_next, 2'b00, note_next.pitch};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      index_reg   <= '0;
      note_reg    <= '0;
      half_reg    <= '0;
      ms_cnt_reg  <= '0;
      tone_en_reg <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      led_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      index_reg   <= index_next;
      note_reg    <= note_next;
      half_reg    <= half_next;
      ms_cnt_reg  <= ms_cnt_next;
      tone_en_reg <= tone_en_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      led_reg     <= led_next;
    end
  end

  assign rom_addr         = index_reg;
  assign tone_half_period = half_reg;
  assign tone_en          = tone_en_reg;
  assign led              = led_reg;
  assign busy             = busy_reg;
  assign done             = done_reg;

endmodule
